nibble_serial_adder: RTL and testbench

- Multi-cycle W-bit adder that feeds the team's 4-bit lookahead_carry_adder one nibble per clock, least significant nibble first.
- The nibble carry is registered between cycles.
- Sits between the operand source (switches/registers) and the result display/accumulator logic.
- Trades latency for area: NIBBLES cycles per add, one start/done handshake per operation.

---
 rtl/nibble_serial_adder.sv | 214 +++++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one 4-bit lookahead slice processes a nibble per clock,
// least significant first, with the inter-nibble carry held in a register.

module lookahead_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] Sum,
  output logic       C_out,
  output logic       PG,
  output logic       GG
);

  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [4:0] c_s;

  assign p_s    = A ^ B;
  assign g_s    = A & B;
  assign c_s[0] = C_in;
  assign c_s[1] = g_s[0] | (p_s[0] & C_in);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & C_in);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & C_in);
  assign c_s[4] = GG | (PG & C_in);
  assign PG     = &p_s;
  assign GG     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
  assign Sum    = p_s ^ c_s[3:0];
  assign C_out  = c_s[4];

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 C_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 C_out,
  output logic                 overflow,
  output logic                 PG,
  output logic                 GG
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      state_q,  state_d;
  logic [IDXW-1:0] idx_q,    idx_d;
  logic            carry_q,  carry_d;
  logic [W-1:0]    a_q,      a_d;
  logic [W-1:0]    b_q,      b_d;
  logic [W-1:0]    work_q,   work_d;
  logic            pg_acc_q, pg_acc_d;
  logic            gg_acc_q, gg_acc_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic [W-1:0]    sum_q,    sum_d;
  logic            c_out_q,  c_out_d;
  logic            ovf_q,    ovf_d;
  logic            pg_q,     pg_d;
  logic            gg_q,     gg_d;

  logic [W-1:0]    a_shift_s;
  logic [W-1:0]    b_shift_s;
  logic [3:0]      slice_sum_s;
  logic            slice_cout_s;
  logic            slice_pg_s;
  logic            slice_gg_s;
  logic [W-1:0]    work_next_s;
  logic            last_s;

  assign a_shift_s = a_q >> {idx_q, 2'b00};
  assign b_shift_s = b_q >> {idx_q, 2'b00};
  assign last_s    = (idx_q == IDXW'(NIBBLES - 1));

  lookahead_carry_adder u_slice (
    .A     (a_shift_s[3:0]),
    .B     (b_shift_s[3:0]),
    .C_in  (carry_q),
    .Sum   (slice_sum_s),
    .C_out (slice_cout_s),
    .PG    (slice_pg_s),
    .GG    (slice_gg_s)
  );

  // Working sum with the current slice result merged into nibble idx.
  always_comb begin
    work_next_s = work_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDXW'(n)) begin
        work_next_s[n*4 +: 4] = slice_sum_s;
      end else begin
        work_next_s[n*4 +: 4] = work_q[n*4 +: 4];
      end
    end
  end

  // Next-state logic: operand capture in IDLE, one nibble per RUN cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    pg_acc_d = pg_acc_q;
    gg_acc_d = gg_acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    pg_d     = pg_q;
    gg_d     = gg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          carry_d  = C_in;
          idx_d    = {IDXW{1'b0}};
          work_d   = {W{1'b0}};
          pg_acc_d = 1'b1;
          gg_acc_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        work_d   = work_next_s;
        carry_d  = slice_cout_s;
        pg_acc_d = pg_acc_q & slice_pg_s;
        gg_acc_d = slice_gg_s | (slice_pg_s & gg_acc_q);
        if (last_s) begin
          sum_d   = work_next_s;
          c_out_d = slice_cout_s;
          pg_d    = pg_acc_q & slice_pg_s;
          gg_d    = slice_gg_s | (slice_pg_s & gg_acc_q);
          // Carry into the MSB recovered from operand and sum bits.
          ovf_d   = (a_q[W-1] ^ b_q[W-1] ^ work_next_s[W-1]) ^ slice_cout_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = {IDXW{1'b0}};
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IDXW{1'b0}};
      carry_q  <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      work_q   <= {W{1'b0}};
      pg_acc_q <= 1'b0;
      gg_acc_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= {W{1'b0}};
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      pg_q     <= 1'b0;
      gg_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      pg_acc_q <= pg_acc_d;
      gg_acc_q <= gg_acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      pg_q     <= pg_d;
      gg_q     <= gg_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Sum      = sum_q;
  assign C_out    = c_out_q;
  assign overflow = ovf_q;
  assign PG       = pg_q;
  assign GG       = gg_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): the driver pushes hand-computed
// results on acceptance, a monitor pops and compares on every done pulse.

module tb_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        pg;
    logic        gg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_s = 16'h0000;
  logic [15:0] b_s = 16'h0000;
  logic        cin_s = 1'b0;
  logic        busy, done, c_out, overflow, pg, gg;
  logic [15:0] sum;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_s), .B(b_s), .C_in(cin_s),
    .busy(busy), .done(done), .Sum(sum), .C_out(c_out), .overflow(overflow),
    .PG(pg), .GG(gg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e = exp_q.pop_front();
        check("sum", {16'h0, sum}, {16'h0, e.sum});
        check("c_out", {31'h0, c_out}, {31'h0, e.cout});
        check("overflow", {31'h0, overflow}, {31'h0, e.ovf});
        check("pg", {31'h0, pg}, {31'h0, e.pg});
        check("gg", {31'h0, gg}, {31'h0, e.gg});
      end
    end
  end

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input exp_t e);
    @(negedge clk);
    a_s = a; b_s = b; cin_s = cin; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a_s = ~a; b_s = ~b; cin_s = ~cin;
  endtask

  // Waits for done after an accept (already at the negedge following it) and checks latency.
  task automatic wait_done(input string name);
    int lat;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) begin
        check({name, "_busy"}, 32'(busy), 32'd1);
      end
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input exp_t e);
    accept(a, b, cin, e);
    wait_done(name);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base_done;
    int prev_cyc;
    #12;
    check("reset_outputs", {busy, done, c_out, overflow, pg, gg, sum}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_busy", {31'h0, busy}, 32'h0);

    run_op("op_1234", 16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});
    run_op("op_ffff1", 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    run_op("op_7fff", 16'h7FFF, 16'h0000, 1'b1, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
    run_op("op_ripple", 16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});

    // start while busy must be ignored
    base_done = done_cnt;
    accept(16'h000F, 16'h0001, 1'b0, '{16'h0010, 1'b0, 1'b0, 1'b0, 1'b0});
    check("hold_sum_midop", {16'h0, sum}, 32'h0000);
    a_s = 16'hAAAA; b_s = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_sum_midop2", {16'h0, sum}, 32'h0000);
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("busy_ignore_done_count", 32'(done_cnt - base_done), 32'd1);
    check("busy_ignore_idle", {31'h0, busy}, 32'h0);

    // reset mid-operation
    base_done = done_cnt;
    accept(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", {busy, done, c_out, overflow, pg, gg, sum}, 32'h0);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    run_op("op_after_reset", 16'h0101, 16'h0202, 1'b0, '{16'h0303, 1'b0, 1'b0, 1'b0, 1'b0});

    // start held high: done every 5 cycles, busy low only in done cycle
    base_done = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back('{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    a_s = 16'h0001; b_s = 16'h0001; cin_s = 1'b0; start = 1'b1;
    prev_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1;
          break;
        end
        if (!busy && prev_cyc >= 0) check("cont_busy_between", 32'(busy), 32'd1);
      end
      check("cont_done_seen", 32'(seen), 32'd1);
      check("cont_busy_at_done", 32'(busy), 32'd0);
      if (prev_cyc >= 0) check("cont_period", 32'(cyc - prev_cyc), 32'd5);
      prev_cyc = cyc;
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("cont_done_count", 32'(done_cnt - base_done), 32'd3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
